// File: rtl/irq_controller.sv
// Memory-mapped 8-line interrupt controller with per-line edge/level mode and claim/complete.
// Optional INTC_SYNC_EN inserts a two-flop synchronizer ahead of the sample register.
module irq_controller #(
  parameter logic [31:0] BASE_ADDR  = 32'hFF200200,
  parameter logic [7:0]  MODE_RESET = 8'hFF
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [7:0]  iIrqSrc,
  input  logic        DwReadEnable,
  input  logic        DwWriteEnable,
  input  logic [3:0]  DwByteEnable,
  input  logic [31:0] DwAddress,
  input  logic [31:0] DwWriteData,
  output logic [31:0] DwReadData,
  output logic [7:0]  oPendingInterrupt
);

  logic [7:0] pending, enable, mode, inservice;
  logic [7:0] src_p0, src_p1;
  logic [7:0] pending_nxt, inservice_nxt, active, rise, src_in;
  logic       rd_q, sel, wr_lane, claim_go, valid;
  logic [1:0] off;
  logic [2:0] id;
  logic       unused_bits;

  assign unused_bits = ^{DwWriteData[31:8], DwAddress[1:0], DwByteEnable[3:1]};

`ifdef INTC_SYNC_EN
  logic [7:0] sync_y1, sync_y2;

  // synchronizer stages for asynchronous sources
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync_y1 <= '0;
      sync_y2 <= '0;
    end else begin
      sync_y1 <= iIrqSrc;
      sync_y2 <= sync_y1;
    end
  end
  assign src_in = sync_y2;
`else
  assign src_in = iIrqSrc;
`endif

  assign sel     = (DwAddress[31:4] == BASE_ADDR[31:4]);
  assign off     = DwAddress[3:2];
  assign wr_lane = DwWriteEnable & sel & DwByteEnable[0];
  assign active  = pending & enable & ~inservice;
  assign rise    = src_p0 & ~src_p1;
  assign oPendingInterrupt = active;

  // lowest-index active line wins the claim
  always_comb begin
    id    = 3'd0;
    valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) begin
        id    = 3'(i);
        valid = 1'b1;
      end
    end
  end

  assign claim_go = DwReadEnable & sel & (off == 2'd3) & ~rd_q & valid;

  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < 8; i++) begin
      if (wr_lane && off == 2'd2 && DwWriteData[i] && !mode[i]) begin
        pending_nxt[i] = 1'b0;
      end else if (mode[i]) begin
        if (rise[i])
          pending_nxt[i] = 1'b1;
        else if ((wr_lane && off == 2'd0 && DwWriteData[i]) || (claim_go && id == 3'(i)))
          pending_nxt[i] = 1'b0;
      end else begin
        pending_nxt[i] = src_p0[i];
      end
    end
  end

  always_comb begin
    inservice_nxt = inservice;
    if (claim_go)
      inservice_nxt[id] = 1'b1;
    if (wr_lane && off == 2'd3)
      inservice_nxt[DwWriteData[2:0]] = 1'b0;
  end

  // sample/previous stages and register state
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      src_p0    <= '0;
      src_p1    <= '0;
      rd_q      <= 1'b0;
      pending   <= '0;
      enable    <= '0;
      mode      <= MODE_RESET;
      inservice <= '0;
    end else begin
      src_p0    <= src_in;
      src_p1    <= src_p0;
      rd_q      <= DwReadEnable & sel;
      pending   <= pending_nxt;
      inservice <= inservice_nxt;
      if (wr_lane && off == 2'd1)
        enable <= DwWriteData[7:0];
      if (wr_lane && off == 2'd2)
        mode <= DwWriteData[7:0];
    end
  end

  always_comb begin
    DwReadData = 32'h0;
    if (DwReadEnable && sel) begin
      case (off)
        2'd0:    DwReadData[7:0] = pending;
        2'd1:    DwReadData[7:0] = enable;
        2'd2:    DwReadData[7:0] = mode;
        default: DwReadData[3:0] = {valid, id};
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: registers, edge/level pending, claim/complete, reset.
module tb_irq_controller;

  localparam logic [31:0] BASE  = 32'hFF200200;
  localparam logic [31:0] A_PND = BASE;
  localparam logic [31:0] A_EN  = BASE + 32'h4;
  localparam logic [31:0] A_MD  = BASE + 32'h8;
  localparam logic [31:0] A_CLM = BASE + 32'hC;
`ifdef INTC_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [7:0]  iIrqSrc = '0;
  logic        DwReadEnable = 1'b0;
  logic        DwWriteEnable = 1'b0;
  logic [3:0]  DwByteEnable = '0;
  logic [31:0] DwAddress = '0;
  logic [31:0] DwWriteData = '0;
  logic [31:0] DwReadData;
  logic [7:0]  oPendingInterrupt;

  int total = 0;
  int bad   = 0;
  logic [31:0] d;

  irq_controller dut (
    .iCLK(iCLK), .iRST(iRST), .iIrqSrc(iIrqSrc),
    .DwReadEnable(DwReadEnable), .DwWriteEnable(DwWriteEnable),
    .DwByteEnable(DwByteEnable), .DwAddress(DwAddress),
    .DwWriteData(DwWriteData), .DwReadData(DwReadData),
    .oPendingInterrupt(oPendingInterrupt)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] be);
    @(negedge iCLK);
    DwWriteEnable = 1'b1; DwAddress = a; DwWriteData = dat; DwByteEnable = be;
    @(negedge iCLK);
    DwWriteEnable = 1'b0; DwByteEnable = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] dat);
    @(negedge iCLK);
    DwReadEnable = 1'b1; DwAddress = a;
    #1 dat = DwReadData;
    @(negedge iCLK);
    DwReadEnable = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] m);
    @(negedge iCLK);
    iIrqSrc = iIrqSrc | m;
    @(negedge iCLK);
    iIrqSrc = iIrqSrc & ~m;
  endtask

  task automatic wait_lat;
    repeat (EXTRA + 1) @(negedge iCLK);
  endtask

  initial begin
    // 1: reset values
    repeat (2) @(posedge iCLK);
    @(negedge iCLK); iRST = 1'b0;
    rd(A_MD, d);  chk("rst_mode", d, 32'h000000FF);
    rd(A_EN, d);  chk("rst_enable", d, 32'h0);
    rd(A_PND, d); chk("rst_pending", d, 32'h0);
    chk("rst_out", {24'h0, oPendingInterrupt}, 32'h0);

    // 2: single edge interrupt, latency, claim, complete
    wr(A_EN, 32'h05, 4'h1);
    pulse(8'h04);
    repeat (EXTRA) @(negedge iCLK);
    chk("lat_early", {24'h0, oPendingInterrupt}, 32'h0);
    @(posedge iCLK); #1;
    chk("lat_out", {24'h0, oPendingInterrupt}, 32'h04);
    rd(A_CLM, d); chk("claim2", d, 32'h0000000A);
    chk("claim2_out", {24'h0, oPendingInterrupt}, 32'h0);
    rd(A_PND, d); chk("claim2_pend", d, 32'h0);
    wr(A_CLM, 32'h2, 4'h1);
    pulse(8'h04); wait_lat;
    chk("complete2", {24'h0, oPendingInterrupt}, 32'h04);
    wr(A_PND, 32'h04, 4'h1);
    rd(A_PND, d); chk("w1c2", d, 32'h0);

    // 3: priority ordering of two simultaneous lines
    wr(A_EN, 32'hFF, 4'h1);
    pulse(8'h21); wait_lat;
    rd(A_CLM, d); chk("claim_a", d, 32'h08);
    rd(A_CLM, d); chk("claim_b", d, 32'h0D);
    rd(A_CLM, d); chk("claim_none", d, 32'h00);
    rd(A_PND, d); chk("claim_none_pend", d, 32'h0);
    wr(A_CLM, 32'h0, 4'h1);
    wr(A_CLM, 32'h5, 4'h1);

    // 4: held read claims once
    pulse(8'h0A); wait_lat;
    @(negedge iCLK); DwReadEnable = 1'b1; DwAddress = A_CLM;
    #1 chk("burst_c0", DwReadData, 32'h09);
    @(negedge iCLK); chk("burst_c1", DwReadData, 32'h0B);
    @(negedge iCLK); chk("burst_c2", DwReadData, 32'h0B);
    @(negedge iCLK); DwReadEnable = 1'b0;
    rd(A_PND, d); chk("burst_pend", d, 32'h08);
    chk("burst_out", {24'h0, oPendingInterrupt}, 32'h08);
    rd(A_CLM, d); chk("burst_claim3", d, 32'h0B);
    wr(A_CLM, 32'h1, 4'h1);
    wr(A_CLM, 32'h3, 4'h1);
    chk("burst_done", {24'h0, oPendingInterrupt}, 32'h0);

    // 5: level mode on line 0
    wr(A_MD, 32'hFE, 4'h1);
    @(negedge iCLK); iIrqSrc[0] = 1'b1;
    wait_lat;
    rd(A_PND, d); chk("lvl_pend", d, 32'h01);
    wr(A_PND, 32'h01, 4'h1);
    rd(A_PND, d); chk("lvl_w1c", d, 32'h01);
    wr(A_MD, 32'hFF, 4'h1);
    rd(A_PND, d); chk("lvl_to_edge_clr", d, 32'h0);
    wr(A_MD, 32'hFE, 4'h1);
    @(negedge iCLK); iIrqSrc[0] = 1'b0;
    repeat (EXTRA) @(negedge iCLK);
    @(negedge iCLK);
    chk("lvl_drop_early", {24'h0, oPendingInterrupt}, 32'h01);
    @(posedge iCLK); #1;
    chk("lvl_drop", {24'h0, oPendingInterrupt}, 32'h0);
    wr(A_MD, 32'hFF, 4'h1);

    // 6: rise beats simultaneous W1C
    @(negedge iCLK); iIrqSrc[4] = 1'b1;
    repeat (EXTRA) @(negedge iCLK);
    @(negedge iCLK);
    iIrqSrc[4] = 1'b0;
    DwWriteEnable = 1'b1; DwAddress = A_PND; DwWriteData = 32'h10; DwByteEnable = 4'h1;
    @(negedge iCLK); DwWriteEnable = 1'b0; DwByteEnable = '0;
    rd(A_PND, d); chk("set_wins", d, 32'h10);
    wr(A_PND, 32'h10, 4'h1);
    rd(A_PND, d); chk("w1c4", d, 32'h0);

    // byte lane and select gating
    wr(A_EN, 32'h3C, 4'h1);
    wr(A_EN, 32'h00, 4'hE);
    rd(A_EN, d); chk("be0_gate", d, 32'h3C);
    wr(BASE + 32'h14, 32'h00, 4'hF);
    rd(A_EN, d); chk("unsel_wr", d, 32'h3C);
    rd(BASE + 32'h14, d); chk("unsel_rd", d, 32'h0);

    // reset in the middle of a claim burst
    wr(A_MD, 32'hF4, 4'h1);
    pulse(8'h04); wait_lat;
    chk("pre_rst_out", {24'h0, oPendingInterrupt}, 32'h04);
    @(negedge iCLK); DwReadEnable = 1'b1; DwAddress = A_CLM; iRST = 1'b1;
    @(negedge iCLK); DwReadEnable = 1'b0; iRST = 1'b0;
    chk("rst2_out", {24'h0, oPendingInterrupt}, 32'h0);
    rd(A_MD, d);  chk("rst2_mode", d, 32'hFF);
    rd(A_EN, d);  chk("rst2_enable", d, 32'h0);
    rd(A_PND, d); chk("rst2_pending", d, 32'h0);
    wr(A_EN, 32'h04, 4'h1);
    pulse(8'h04); wait_lat;
    chk("rst2_inservice", {24'h0, oPendingInterrupt}, 32'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller on the CPU data bus; produces the CPU's 8-bit pending-interrupt input (iPendingInterrupt).
- Collects 8 raw peripheral IRQ lines. Supports per-line edge or level mode. Provides pending, enable and claim/complete registers.
- CPU software claims and completes interrupts through loads and stores.

Parameters:
- BASE_ADDR, 32'hFF200200, register block base; must be 16-byte aligned.
- MODE_RESET, 8'hFF, reset value of MODE register (1 = edge, 0 = level).

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  reset.
- iIrqSrc  in  8  raw peripheral interrupt lines, active-high.
- DwReadEnable  in  1  bus read strobe.
- DwWriteEnable  in  1  bus write strobe.
- DwByteEnable  in  4  write byte lanes.
- DwAddress  in  32  bus address.
- DwWriteData  in  32  bus write data.
- DwReadData  out  32  read data; 0 when not selected.
- oPendingInterrupt  out  8  pending & enable & ~inservice, to CPU iPendingInterrupt.

Interface rule:
- One clock (iCLK). Reset iRST is synchronous and active-high.

Behaviour:
- Select: sel = (DwAddress[31:4] == BASE_ADDR[31:4]). Register offset is DwAddress[3:2].
- Offset 0, PENDING[7:0]:
  - Read returns the pending bits.
  - Write with DwByteEnable[0]: write-1-to-clear, edge-mode bits only.
- Offset 1, ENABLE[7:0]: read/write, byte lane 0.
- Offset 2, MODE[7:0]: read/write, byte lane 0.
- Offset 3, CLAIM:
  - Read returns {24'b0, 4'b0, valid, id[2:0]}.
  - id is the lowest index with pending & enable & ~inservice; valid = 1 if any such line exists.
- Offset 3 write (complete): if DwByteEnable[0] and inservice[DwWriteData[2:0]] is set, clear that bit. Otherwise ignored.
- DwReadData:
  - Combinational, same cycle as DwReadEnable & sel. Upper bits are zero.
  - 32'h0 when not selected, so it can be OR-merged into the bus.
- Input path:
  - sample register s = iIrqSrc every edge; prev register p = s.
  - Edge-mode rise detect: s & ~p.
- Pending update each edge, per bit i:
  - Edge mode: set on rise; else clear on W1C; else hold. Set wins over a simultaneous W1C.
  - Level mode: pending[i] = s[i]. W1C has no effect.
  - Changing MODE of a bit from level to edge clears that pending bit.
- Claim side effect occurs only on the first cycle of a read burst:
  - Condition: DwReadEnable & sel & offset 3 & ~rd_q, where rd_q is DwReadEnable & sel registered.
  - Multicycle CPUs holding DwReadEnable therefore claim once.
  - At that edge, if valid: inservice[id] set; if that line is edge mode, pending[id] cleared.
  - A new rise on the same line in the same cycle re-sets pending (set wins).
- Claim and complete of different ids may not occur together; a write and a read are never simultaneous on the bus.
- Latency without INTC_SYNC_EN:
  - iIrqSrc high before edge E0 → pending set at E1 → oPendingInterrupt high after E1.
  - Total: 2 edges.
- Reset (synchronous, iRST=1 at an edge):
  - PENDING=0, ENABLE=0, MODE=MODE_RESET, inservice=0, s=p=rd_q=0.
  - Synchronizer cleared.
  - oPendingInterrupt=0 the cycle after.
  - Reset mid-burst discards any claim in progress.
- Writes with DwByteEnable[0]=0 change nothing. Unselected accesses change nothing.

Optional Feature:
- Macro: INTC_SYNC_EN.
- Defined:
  - Two-flop synchronizer (y1, y2) precedes the sample register for asynchronous sources.
  - Rise and level paths use the synchronized value.
  - Latency to oPendingInterrupt becomes 4 edges.
  - Synchronizer flops reset to 0.
- Undefined: iIrqSrc feeds s directly; latency is 2 edges.

Test Plan:
1. Reset, then read MODE, ENABLE and PENDING → 8'hFF, 0, 0. oPendingInterrupt=0.
2. Write ENABLE=8'h05, pulse iIrqSrc[2] for 1 cycle:
   - oPendingInterrupt=8'h04 after 2 edges (4 with INTC_SYNC_EN).
   - CLAIM read returns 32'h0000000A.
   - oPendingInterrupt=0 next cycle.
   - Write 2 to CLAIM → inservice cleared.
3. ENABLE=8'hFF, pulse lines 0 and 5 together:
   - First claim → 32'h08, second claim → 32'h0D.
   - Third claim → 32'h00 with no state change.
4. Hold DwReadEnable on CLAIM for 3 cycles with lines 1 and 3 pending → only line 1 claimed; line 3 still pending.
5. MODE=8'hFE, hold iIrqSrc[0] high:
   - PENDING[0]=1; W1C of 1 leaves it 1.
   - Drop iIrqSrc[0] → PENDING[0]=0 after 2 edges.
6. Pulse line 4 in the same cycle as a W1C of 8'h10 → PENDING[4]=1. Assert iRST mid-sequence → all registers at reset values.
